// File: rtl/ysyx_22040125_if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM encoding, reset PC and bubble instruction.
package ysyx_22040125_if_fetch_pkg;

   localparam int          XLEN     = 64;
   localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_FULL = 3'd3,
      S_DROP = 3'd4
   } fetch_state_t;

   function automatic logic [63:0] align_pc(input logic [63:0] pc);
      return {pc[63:2], 2'b00};
   endfunction

endpackage

// File: rtl/ysyx_22040125_if_fetch.sv
// Instruction-fetch stage: single-outstanding imem requests, one-entry instruction buffer,
// stall handling and redirect with wrong-path response discard.
module ysyx_22040125_if_fetch
   import ysyx_22040125_if_fetch_pkg::*;
#(
   parameter logic [63:0] RESET_PC_P = RESET_PC,
   parameter logic [31:0] NOP_INST_P = NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] inst,
   output logic [63:0] if_pc,
   output logic        if_valid
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [63:0]  r_pc;
   logic [63:0]  w_pc_nxt;
   logic [31:0]  r_buf;
   logic [31:0]  w_buf_nxt;
   logic [63:0]  w_redirect_pc;

   assign w_redirect_pc = align_pc(redirect_pc);

   // State, PC and instruction buffer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC_P;
         r_buf   <= NOP_INST_P;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_buf   <= w_buf_nxt;
      end
   end

   // Next-state / next-pc logic; redirect always takes priority.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_buf_nxt   = r_buf;
      case (r_state)
         S_IDLE: begin
            if (redirect_valid) begin
               w_pc_nxt = w_redirect_pc;
            end else begin
               w_pc_nxt = r_pc;
            end
            w_state_nxt = S_REQ;
         end
         S_REQ: begin
            if (redirect_valid) begin
               w_pc_nxt    = w_redirect_pc;
               w_state_nxt = imem_req_ready ? S_DROP : S_REQ;
            end else if (imem_req_ready) begin
               w_state_nxt = S_WAIT;
            end else begin
               w_state_nxt = S_REQ;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               w_pc_nxt    = w_redirect_pc;
               w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
            end else if (imem_rsp_valid) begin
               w_buf_nxt   = imem_rsp_data;
               w_state_nxt = S_FULL;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         S_FULL: begin
            if (redirect_valid) begin
               w_pc_nxt    = w_redirect_pc;
               w_state_nxt = S_REQ;
            end else if (!stall) begin
               w_pc_nxt    = r_pc + 64'd4;
               w_state_nxt = S_REQ;
            end else begin
               w_state_nxt = S_FULL;
            end
         end
         S_DROP: begin
            // A redirect arriving with the stale response must still retire it, or we would wait forever.
            if (redirect_valid) begin
               w_pc_nxt    = w_redirect_pc;
               w_state_nxt = imem_rsp_valid ? S_REQ : S_DROP;
            end else if (imem_rsp_valid) begin
               w_state_nxt = S_REQ;
            end else begin
               w_state_nxt = S_DROP;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_pc_nxt    = RESET_PC_P;
            w_buf_nxt   = NOP_INST_P;
         end
      endcase
   end

   assign imem_req_valid = (r_state == S_REQ);
   assign imem_addr      = r_pc;
   assign if_valid       = (r_state == S_FULL);
   assign inst           = (r_state == S_FULL) ? r_buf : NOP_INST_P;
   assign if_pc          = r_pc;

endmodule
